// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline-control slice: status encodings,
// control-bundle defaults and the bubble constant.
package pipe_pkg;

  localparam int CTRL_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FLUSH  = 2'd3
  } pipe_state_e;

  // A bubble carries no side effects downstream, so the whole bundle is zero.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;

  function automatic logic counts_as_stall(pipe_state_e s);
    return (s == ST_HOLD) || (s == ST_BUBBLE);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operand/control bundle in, registered EX-side copy out.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
);
    logic              valid_ID;
    logic [XLEN-1:0]   pc_ID;
    logic [XLEN-1:0]   rs1_data_ID;
    logic [XLEN-1:0]   rs2_data_ID;
    logic [XLEN-1:0]   imm_ID;
    logic [4:0]        RS1_ID;
    logic [4:0]        RS2_ID;
    logic [4:0]        RD_ID;
    logic              use_rs1_ID;
    logic              use_rs2_ID;
    logic              RegWEn_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic [CTRL_W-1:0] ctrl_ID;

    logic              valid_EX;
    logic [XLEN-1:0]   pc_EX;
    logic [XLEN-1:0]   rs1_data_EX;
    logic [XLEN-1:0]   rs2_data_EX;
    logic [XLEN-1:0]   imm_EX;
    logic [4:0]        RS1_EX;
    logic [4:0]        RS2_EX;
    logic [4:0]        RD_EX;
    logic              RegWEn_EX;
    logic              MemRead_EX;
    logic              MemWrite_EX;
    logic [CTRL_W-1:0] ctrl_EX;

    // master: decode side feeding ID and consuming EX; slave: the stage itself
    modport master (
        output valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
               RS1_ID, RS2_ID, RD_ID, use_rs1_ID, use_rs2_ID,
               RegWEn_ID, MemRead_ID, MemWrite_ID, ctrl_ID,
        input  valid_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX,
               RS1_EX, RS2_EX, RD_EX, RegWEn_EX, MemRead_EX, MemWrite_EX, ctrl_EX
    );

    modport slave (
        input  valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
               RS1_ID, RS2_ID, RD_ID, use_rs1_ID, use_rs2_ID,
               RegWEn_ID, MemRead_ID, MemWrite_ID, ctrl_ID,
        output valid_EX, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX,
               RS1_EX, RS2_EX, RD_EX, RegWEn_EX, MemRead_EX, MemWrite_EX, ctrl_EX
    );
endinterface

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// data-memory freeze and saturating stall/flush counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    id_ex_stage_if.slave     bus,
    input  logic             br_taken_EX,
    input  logic             dmem_busy,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_ID,
    output logic [1:0]       pipe_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [4:0]        rs1_q,      rs1_d;
    logic [4:0]        rs2_q,      rs2_d;
    logic [4:0]        rd_q,       rd_d;
    logic              regwen_q,   regwen_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    pipe_state_e       state_q,    state_d;

    logic        load_use;
    pipe_state_e evt;
    logic        stall_inc, flush_inc;

    // Hazard check uses only registered EX state, so a bubble can never re-trigger it.
    always_comb begin
        load_use = valid_q & memread_q & (rd_q != 5'd0) & bus.valid_ID &
                   ((bus.use_rs1_ID & (bus.RS1_ID == rd_q)) |
                    (bus.use_rs2_ID & (bus.RS2_ID == rd_q)));
        if (dmem_busy)        evt = ST_HOLD;
        else if (br_taken_EX) evt = ST_FLUSH;
        else if (load_use)    evt = ST_BUBBLE;
        else                  evt = ST_RUN;
    end

    assign stall_IF  = (evt == ST_HOLD) || (evt == ST_BUBBLE);
    assign stall_ID  = stall_IF;
    assign flush_ID  = (evt == ST_FLUSH);
    assign stall_inc = counts_as_stall(evt);
    assign flush_inc = (evt == ST_FLUSH);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        regwen_d   = regwen_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        ctrl_d     = ctrl_q;
        state_d    = evt;
        case (evt)
            ST_RUN: begin
                valid_d    = bus.valid_ID;
                pc_d       = bus.pc_ID;
                rs1_data_d = bus.rs1_data_ID;
                rs2_data_d = bus.rs2_data_ID;
                imm_d      = bus.imm_ID;
                rs1_d      = bus.RS1_ID;
                rs2_d      = bus.RS2_ID;
                rd_d       = bus.RD_ID;
                // Never advertise a write to x0 so forwarding cannot match it.
                regwen_d   = bus.RegWEn_ID & bus.valid_ID & (bus.RD_ID != 5'd0);
                memread_d  = bus.MemRead_ID;
                memwrite_d = bus.MemWrite_ID;
                ctrl_d     = bus.ctrl_ID;
            end
            ST_BUBBLE, ST_FLUSH: begin
                valid_d    = 1'b0;
                rs1_d      = 5'd0;
                rs2_d      = 5'd0;
                rd_d       = 5'd0;
                regwen_d   = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                ctrl_d     = CTRL_W'(CTRL_BUBBLE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            regwen_q   <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            ctrl_q     <= '0;
            state_q    <= ST_RUN;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            regwen_q   <= regwen_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            ctrl_q     <= ctrl_d;
            state_q    <= state_d;
        end
    end

    assign bus.valid_EX    = valid_q;
    assign bus.pc_EX       = pc_q;
    assign bus.rs1_data_EX = rs1_data_q;
    assign bus.rs2_data_EX = rs2_data_q;
    assign bus.imm_EX      = imm_q;
    assign bus.RS1_EX      = rs1_q;
    assign bus.RS2_EX      = rs2_q;
    assign bus.RD_EX       = rd_q;
    assign bus.RegWEn_EX   = regwen_q;
    assign bus.MemRead_EX  = memread_q;
    assign bus.MemWrite_EX = memwrite_q;
    assign bus.ctrl_EX     = ctrl_q;
    assign pipe_state      = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus freeze/reset/saturation sequences.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .CTRL_W(12)) bus ();
    id_ex_stage_if #(.XLEN(32), .CTRL_W(12)) bus4 ();

    logic        br_taken_EX, dmem_busy;
    logic        stall_IF, stall_ID, flush_ID;
    logic [1:0]  pipe_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        busy4;
    logic        stall_IF4, stall_ID4, flush_ID4;
    logic [1:0]  pipe_state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    id_ex_stage #(.XLEN(32), .CTRL_W(12), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .br_taken_EX(br_taken_EX), .dmem_busy(dmem_busy),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
        .pipe_state(pipe_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.XLEN(32), .CTRL_W(12), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4),
        .br_taken_EX(1'b0), .dmem_busy(busy4),
        .stall_IF(stall_IF4), .stall_ID(stall_ID4), .flush_ID(flush_ID4),
        .pipe_state(pipe_state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        logic       vid;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, we, mr, br;
        logic       xstall, xflush;
        logic       xvalid, xwe;
        logic [4:0] xrd, xrs1;
        logic [1:0] xst;
        logic [15:0] xsc, xfc;
    } vec_t;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic vid, logic [4:0] rs1, rs2, rd, logic u1, u2, we, mr, br,
                                logic xstall, xflush, xvalid, xwe, logic [4:0] xrd, xrs1,
                                logic [1:0] xst, logic [15:0] xsc, xfc);
        vec_t v;
        v.vid = vid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.we = we; v.mr = mr; v.br = br;
        v.xstall = xstall; v.xflush = xflush; v.xvalid = xvalid; v.xwe = xwe;
        v.xrd = xrd; v.xrs1 = xrs1; v.xst = xst; v.xsc = xsc; v.xfc = xfc;
        return v;
    endfunction

    task automatic drive_id(input logic vid, input logic [4:0] rs1, rs2, rd,
                            input logic u1, u2, we, mr, input logic [31:0] pc);
        bus.valid_ID    = vid;
        bus.RS1_ID      = rs1;
        bus.RS2_ID      = rs2;
        bus.RD_ID       = rd;
        bus.use_rs1_ID  = u1;
        bus.use_rs2_ID  = u2;
        bus.RegWEn_ID   = we;
        bus.MemRead_ID  = mr;
        bus.MemWrite_ID = 1'b0;
        bus.pc_ID       = pc;
        bus.rs1_data_ID = $urandom;
        bus.rs2_data_ID = $urandom;
        bus.imm_ID      = $urandom;
        bus.ctrl_ID     = 12'(pc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        br_taken_EX = 0; dmem_busy = 0; busy4 = 0;
        bus4.valid_ID = 0; bus4.pc_ID = 0; bus4.rs1_data_ID = 0; bus4.rs2_data_ID = 0;
        bus4.imm_ID = 0; bus4.RS1_ID = 0; bus4.RS2_ID = 0; bus4.RD_ID = 0;
        bus4.use_rs1_ID = 0; bus4.use_rs2_ID = 0; bus4.RegWEn_ID = 0;
        bus4.MemRead_ID = 0; bus4.MemWrite_ID = 0; bus4.ctrl_ID = 0;

        //                vid rs1 rs2 rd u1 u2 we mr br | st fl  v we rd rs1 state sc fc
        tbl[0] = mk(1, 1, 0, 5,  1, 0, 1, 1, 0,   0, 0, 1, 1, 5,  1, 0, 0, 0); // lw x5
        tbl[1] = mk(1, 5, 7, 6,  1, 1, 1, 0, 0,   1, 0, 0, 0, 0,  0, 1, 1, 0); // add x6,x5,x7 -> bubble
        tbl[2] = mk(1, 5, 7, 6,  1, 1, 1, 0, 0,   0, 0, 1, 1, 6,  5, 0, 1, 0); // add enters EX
        tbl[3] = mk(1, 2, 0, 0,  1, 0, 1, 1, 0,   0, 0, 1, 0, 0,  2, 0, 1, 0); // lw x0: RegWEn dropped
        tbl[4] = mk(1, 0, 0, 8,  1, 0, 1, 0, 0,   0, 0, 1, 1, 8,  0, 0, 1, 0); // reads x0 after lw x0
        tbl[5] = mk(1, 3, 0, 9,  1, 0, 1, 1, 0,   0, 0, 1, 1, 9,  3, 0, 1, 0); // lw x9
        tbl[6] = mk(1, 4, 9, 10, 1, 0, 0, 0, 0,   0, 0, 1, 0, 10, 4, 0, 1, 0); // rs2 match but unused
        tbl[7] = mk(1, 1, 0, 11, 1, 0, 1, 1, 0,   0, 0, 1, 1, 11, 1, 0, 1, 0); // lw x11
        tbl[8] = mk(1, 0, 11, 12, 0, 1, 1, 0, 1,  0, 1, 0, 0, 0,  0, 3, 1, 1); // branch beats load-use
        tbl[9] = mk(0, 5, 0, 13, 1, 0, 1, 0, 0,   0, 0, 0, 0, 13, 5, 0, 1, 1); // invalid ID

        // Reset held with random ID traffic
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 1, 1, $urandom);
            tick();
        end
        chk("rst_valid", 32'(bus.valid_EX), 0);
        chk("rst_regwen", 32'(bus.RegWEn_EX), 0);
        chk("rst_rd", 32'(bus.RD_EX), 0);
        chk("rst_state", 32'(pipe_state), 0);
        chk("rst_scnt", 32'(stall_cnt), 0);
        chk("rst_fcnt", 32'(flush_cnt), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive_id(tbl[i].vid, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                     tbl[i].u1, tbl[i].u2, tbl[i].we, tbl[i].mr, 32'(i * 4));
            br_taken_EX = tbl[i].br;
            #1;
            chk($sformatf("v%0d_stall_IF", i), 32'(stall_IF), 32'(tbl[i].xstall));
            chk($sformatf("v%0d_stall_ID", i), 32'(stall_ID), 32'(tbl[i].xstall));
            chk($sformatf("v%0d_flush_ID", i), 32'(flush_ID), 32'(tbl[i].xflush));
            tick();
            chk($sformatf("v%0d_valid_EX", i), 32'(bus.valid_EX), 32'(tbl[i].xvalid));
            chk($sformatf("v%0d_RegWEn_EX", i), 32'(bus.RegWEn_EX), 32'(tbl[i].xwe));
            chk($sformatf("v%0d_RD_EX", i), 32'(bus.RD_EX), 32'(tbl[i].xrd));
            chk($sformatf("v%0d_RS1_EX", i), 32'(bus.RS1_EX), 32'(tbl[i].xrs1));
            chk($sformatf("v%0d_state", i), 32'(pipe_state), 32'(tbl[i].xst));
            chk($sformatf("v%0d_scnt", i), 32'(stall_cnt), 32'(tbl[i].xsc));
            chk($sformatf("v%0d_fcnt", i), 32'(flush_cnt), 32'(tbl[i].xfc));
        end
        br_taken_EX = 0;

        // Memory freeze with a pending branch
        drive_id(1, 1, 0, 14, 1, 0, 1, 1, 32'h100);
        tick();
        chk("frz_pre_rd", 32'(bus.RD_EX), 14);
        for (int k = 0; k < 3; k++) begin
            drive_id(1, 14, 14, 5'(20 + k), 1, 1, 1, 0, 32'h200 + 32'(k));
            dmem_busy = 1; br_taken_EX = 1;
            #1;
            chk($sformatf("frz%0d_stall_IF", k), 32'(stall_IF), 1);
            chk($sformatf("frz%0d_flush_ID", k), 32'(flush_ID), 0);
            tick();
            chk($sformatf("frz%0d_pc_EX", k), bus.pc_EX, 32'h100);
            chk($sformatf("frz%0d_RD_EX", k), 32'(bus.RD_EX), 14);
            chk($sformatf("frz%0d_valid", k), 32'(bus.valid_EX), 1);
            chk($sformatf("frz%0d_state", k), 32'(pipe_state), 2);
        end
        chk("frz_scnt", 32'(stall_cnt), 4);
        dmem_busy = 0;
        #1;
        chk("rel_flush_ID", 32'(flush_ID), 1);
        chk("rel_stall_IF", 32'(stall_IF), 0);
        tick();
        chk("rel_state", 32'(pipe_state), 3);
        chk("rel_valid", 32'(bus.valid_EX), 0);
        chk("rel_fcnt", 32'(flush_cnt), 2);
        chk("rel_scnt", 32'(stall_cnt), 4);
        br_taken_EX = 0;

        // Async reset in the middle of a HOLD
        drive_id(1, 1, 0, 15, 0, 0, 1, 0, 32'h300);
        tick();
        dmem_busy = 1;
        tick();
        chk("hold_state", 32'(pipe_state), 2);
        chk("hold_rd", 32'(bus.RD_EX), 15);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", 32'(bus.valid_EX), 0);
        chk("arst_rd", 32'(bus.RD_EX), 0);
        chk("arst_regwen", 32'(bus.RegWEn_EX), 0);
        chk("arst_state", 32'(pipe_state), 0);
        chk("arst_scnt", 32'(stall_cnt), 0);
        #1 reset_n = 1; dmem_busy = 0;
        drive_id(1, 2, 0, 16, 0, 0, 1, 0, 32'h400);
        tick();
        chk("post_rst_valid", 32'(bus.valid_EX), 1);
        chk("post_rst_rd", 32'(bus.RD_EX), 16);
        chk("post_rst_state", 32'(pipe_state), 0);
        chk("post_rst_scnt", 32'(stall_cnt), 0);

        // 4-bit counter saturates
        busy4 = 1;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_stall_IF4", 32'(stall_IF4), 1);
        chk("sat_state4", 32'(pipe_state4), 2);
        chk("sat_scnt4", 32'(stall_cnt4), 15);
        chk("sat_fcnt4", 32'(flush_cnt4), 0);
        busy4 = 0;
        tick();
        chk("sat_hold4", 32'(stall_cnt4), 15);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
